// File: rtl/cdc_pkg.sv
// Shared definitions for the clk_tx-side handshake controller.
package cdc_pkg;

  // Handshake controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } hs_state_e;

  // Number of cycles a phase may wait for the acknowledge before giving up.
  function automatic int unsigned to_limit(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Walk the requesters starting at the pointer and keep the first hit.
  always_comb begin
    int  cand;
    logic hit;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    hit   = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      hit  = !any_o && req_i[IW'(cand)];
      gnt_o[IW'(cand)] = gnt_o[IW'(cand)] | hit;
      idx_o = hit ? IW'(cand) : idx_o;
      any_o = any_o | hit;
    end
  end

endmodule

// File: rtl/cdc_hs_arbiter.sv
// Transmit-side controller: round-robin grant, word capture and 4-phase
// req/ack sequencing toward a two-flop synchronizer, with stuck-ack timeout.
module cdc_hs_arbiter
  import cdc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TO_W    = 8
) (
  input  logic                        clk_tx,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        xfer_req,
  output logic [DATA_W-1:0]           xfer_data,
  input  logic                        xfer_ack_sync,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        done,
  output logic                        to_err,
  input  logic                        err_clr
);

  localparam int GID_W = $clog2(NUM_REQ);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(to_limit(TO_W));
  localparam logic [GID_W-1:0] LAST_ID  = GID_W'(NUM_REQ - 1);

  hs_state_e          state_q, state_d;
  logic [GID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TO_W-1:0]    cnt_q, cnt_d;
  logic [TO_W-1:0]    cnt_inc;
  logic [DATA_W-1:0]  xfer_data_q, xfer_data_d;
  logic [GID_W-1:0]   grant_id_q, grant_id_d;
  logic               xfer_req_q, xfer_req_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               to_err_q, to_err_d;
  logic               tout_q, tout_d;   // a timeout already hit this transfer
  logic               set_err;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [GID_W-1:0]   arb_idx;
  logic               arb_any;
  logic [DATA_W-1:0]  win_data;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (GID_W)
  ) u_rr_arbiter (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // One-hot AND-OR mux of the winning requester's data word.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_data = win_data | (req_data[i*DATA_W +: DATA_W] & {DATA_W{arb_gnt[i]}});
    end
  end

  // Next-state, grant, timeout and output-register computation.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    xfer_data_d = xfer_data_q;
    grant_id_d  = grant_id_q;
    tout_d      = tout_q;
    done_d      = 1'b0;
    set_err     = 1'b0;
    req_ready   = '0;
    cnt_inc     = cnt_q + TO_W'(1);

    case (state_q)
      IDLE: begin
        // A still-high ack belongs to the previous transfer: hold off.
        if (arb_any && !xfer_ack_sync) begin
          req_ready   = arb_gnt;
          xfer_data_d = win_data;
          grant_id_d  = arb_idx;
          rr_ptr_d    = (arb_idx == LAST_ID) ? '0 : arb_idx + GID_W'(1);
          cnt_d       = '0;
          tout_d      = 1'b0;
          state_d     = REQ;
        end else begin
          state_d     = IDLE;
        end
      end
      REQ: begin
        if (xfer_ack_sync) begin
          cnt_d   = '0;
          state_d = REL;
        end else if (cnt_inc == TO_LIMIT) begin
          cnt_d   = '0;
          set_err = 1'b1;
          tout_d  = 1'b1;
          state_d = REL;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      REL: begin
        if (!xfer_ack_sync) begin
          done_d  = !tout_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_inc == TO_LIMIT) begin
          set_err = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // A new timeout beats a simultaneous clear.
    if (set_err) begin
      to_err_d = 1'b1;
    end else if (err_clr) begin
      to_err_d = 1'b0;
    end else begin
      to_err_d = to_err_q;
    end

    xfer_req_d = (state_d == REQ);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers; reset drops xfer_req immediately.
  always_ff @(posedge clk_tx or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      xfer_data_q <= '0;
      grant_id_q  <= '0;
      xfer_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      to_err_q    <= 1'b0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      xfer_data_q <= xfer_data_d;
      grant_id_q  <= grant_id_d;
      xfer_req_q  <= xfer_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      to_err_q    <= to_err_d;
      tout_q      <= tout_d;
    end
  end

  assign xfer_req  = xfer_req_q;
  assign xfer_data = xfer_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign to_err    = to_err_q;

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// Bench for cdc_hs_arbiter: directed scenarios plus randomized traffic,
// all checked against a transfer-level reference model.
module tb_cdc_hs_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int TW  = 4;
  localparam int LIM = 15;

  logic            clk_tx = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            xfer_req;
  logic [DW-1:0]   xfer_data;
  logic            xfer_ack_sync;
  logic [1:0]      grant_id;
  logic            busy;
  logic            done;
  logic            to_err;
  logic            err_clr;

  cdc_hs_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TO_W(TW)) dut (
    .clk_tx        (clk_tx),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .xfer_req      (xfer_req),
    .xfer_data     (xfer_data),
    .xfer_ack_sync (xfer_ack_sync),
    .grant_id      (grant_id),
    .busy          (busy),
    .done          (done),
    .to_err        (to_err),
    .err_clr       (err_clr)
  );

  always #5 clk_tx = ~clk_tx;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: phase 0 = idle, 1 = request outstanding, 2 = releasing.
  int            m_ph, m_cnt, m_ptr, m_gid;
  logic [DW-1:0] m_data;
  bit            m_err, m_timed, m_done;
  logic [N-1:0]  rdy_seen;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_ptr = 0; m_gid = 0; m_data = '0;
    m_err = 1'b0; m_timed = 1'b0; m_done = 1'b0; rdy_seen = '0;
  endtask

  // One clock: check the accept pulse, advance the model, check registers.
  task automatic step();
    int sel;
    logic [N-1:0] exp_rdy;
    bit set_err;
    #1;
    sel = -1;
    exp_rdy = '0;
    if (m_ph == 0 && !xfer_ack_sync) sel = pick(req_valid, m_ptr);
    if (sel >= 0) exp_rdy[sel] = 1'b1;
    rdy_seen = req_ready;
    check("req_ready", req_ready, exp_rdy);

    set_err = 1'b0;
    m_done  = 1'b0;
    if (m_ph == 0) begin
      if (sel >= 0) begin
        m_ph = 1; m_cnt = 0; m_timed = 1'b0;
        m_data = req_data[sel*DW +: DW];
        m_gid = sel;
        m_ptr = (sel + 1) % N;
      end
    end else if (m_ph == 1) begin
      m_cnt++;
      if (xfer_ack_sync) begin
        m_ph = 2; m_cnt = 0;
      end else if (m_cnt == LIM) begin
        m_ph = 2; m_cnt = 0; set_err = 1'b1; m_timed = 1'b1;
      end
    end else begin
      m_cnt++;
      if (!xfer_ack_sync) begin
        m_ph = 0; m_cnt = 0; m_done = !m_timed;
      end else if (m_cnt == LIM) begin
        m_ph = 0; m_cnt = 0; set_err = 1'b1;
      end
    end
    if (set_err) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;

    @(posedge clk_tx);
    #1;
    check("xfer_req", xfer_req, (m_ph == 1));
    check("busy", busy, (m_ph != 0));
    check("xfer_data", xfer_data, m_data);
    check("grant_id", grant_id, m_gid);
    check("done", done, m_done);
    check("to_err", to_err, m_err);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req_valid = '0; req_data = '0; xfer_ack_sync = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_tx);
    #1;
    rst_n = 1'b1;
    check("rst_xfer_req", xfer_req, 1'b0);
    check("rst_xfer_data", xfer_data, 8'h00);
    check("rst_grant_id", grant_id, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_to_err", to_err, 1'b0);
  endtask

  // Drive ack from the model's view of the protocol until idle again.
  task automatic drain();
    for (int i = 0; i < 40 && m_ph != 0; i++) begin
      xfer_ack_sync = (m_ph == 1);
      step();
    end
    xfer_ack_sync = 1'b0;
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int q[$];
    int exp_rr[6];
    int hi, n_hi, slow;
    bit done_seen;
    exp_rr = '{0, 1, 2, 3, 0, 1};

    // Single transfer with data churn on the granted requester.
    apply_reset();
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 8'hA5;
    step();
    check("t1_ready", rdy_seen, 4'b0100);
    check("t1_xreq", xfer_req, 1'b1);
    check("t1_xdata", xfer_data, 8'hA5);
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      req_data = $urandom();
      step();
      check("t1_hold", xfer_data, 8'hA5);
    end
    xfer_ack_sync = 1'b1;
    req_data = $urandom();
    step();
    check("t1_req_low", xfer_req, 1'b0);
    check("t1_rel_data", xfer_data, 8'hA5);
    xfer_ack_sync = 1'b0;
    step();
    check("t1_done", done, 1'b1);
    check("t1_gid", grant_id, 2'd2);
    step();
    check("t1_done_pulse", done, 1'b0);

    // Round-robin with all requesters held valid, ack two cycles after req.
    apply_reset();
    req_valid = 4'hF;
    hi = 0;
    for (int c = 0; c < 60; c++) begin
      req_data = $urandom();
      step();
      if (rdy_seen != '0) q.push_back(pick(rdy_seen, 0));
      if (m_ph == 1) begin
        hi++;
        if (hi >= 2) xfer_ack_sync = 1'b1;
      end else begin
        hi = 0;
        xfer_ack_sync = 1'b0;
      end
    end
    for (int i = 0; i < 6; i++) begin
      check("rr_order", (i < q.size()) ? q[i] : -1, exp_rr[i]);
    end
    req_valid = '0;
    drain();

    // Request timeout with ack never rising.
    apply_reset();
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    n_hi = int'(xfer_req);
    done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (xfer_req) n_hi++;
      if (done) done_seen = 1'b1;
    end
    check("to_req_cycles", n_hi, 15);
    check("to_err_set", to_err, 1'b1);
    check("to_no_done", done_seen, 1'b0);
    check("to_idle", busy, 1'b0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("to_clr", to_err, 1'b0);
    // Clear coinciding with the timeout cycle.
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    repeat (14) step();
    check("to_pre_err", to_err, 1'b0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("to_set_wins", to_err, 1'b1);
    check("to_set_req", xfer_req, 1'b0);
    step();

    // Stale ack in IDLE blocks the grant until it falls.
    xfer_ack_sync = 1'b1;
    req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stale_no_rdy", rdy_seen, 4'b0000);
    end
    xfer_ack_sync = 1'b0;
    step();
    check("stale_grant", rdy_seen, 4'b0001);
    req_valid = '0;
    drain();

    // Reset while a request is outstanding.
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 8'h3C;
    step();
    req_valid = '0;
    step();
    check("mr_pre_req", xfer_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mr_xfer_req", xfer_req, 1'b0);
    check("mr_busy", busy, 1'b0);
    check("mr_to_err", to_err, 1'b0);
    check("mr_xfer_data", xfer_data, 8'h00);
    model_reset();
    repeat (2) @(posedge clk_tx);
    #1;
    rst_n = 1'b1;
    req_valid = 4'hF;
    step();
    check("mr_first_grant", rdy_seen, 4'b0001);
    req_valid = '0;
    drain();

    // Randomized traffic with a responder that is sometimes slow or stuck.
    apply_reset();
    slow = 2;
    for (int c = 0; c < 1500; c++) begin
      req_valid = req_valid & ~rdy_seen;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) req_valid[i] = ($urandom_range(3) == 0);
        else if ($urandom_range(31) == 0) req_valid[i] = 1'b0;
      end
      req_data = $urandom();
      if (m_ph == 0) slow = $urandom_range(9);
      if (m_ph == 1) begin
        if (slow != 0 && $urandom_range(3) == 0) xfer_ack_sync = 1'b1;
      end else if (m_ph == 2 && slow == 1) begin
        xfer_ack_sync = 1'b1;
      end else if ($urandom_range(2) == 0) begin
        xfer_ack_sync = 1'b0;
      end else if (m_ph == 0 && $urandom_range(15) == 0) begin
        xfer_ack_sync = 1'b1;
      end
      err_clr = ($urandom_range(15) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
